// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch requester, data requester and SRAM port signals of
// mem_port_arbiter.
//   slave  : the arbiter's view. Requests and SRAM read data come in;
//            handshakes, read data and the SRAM drive go out.
//   master : the environment's view (requesters plus SRAM).
// Signal groups:
//   i_*    fetch stage: i_req, i_addr, i_cancel -> i_addr_ok, i_data_ok, i_rdata
//   d_*    execute stage: d_req, d_we, d_addr, d_wdata -> d_addr_ok, d_data_ok, d_rdata
//   sram_* single SRAM port: sram_en, sram_we, sram_addr, sram_wdata <- sram_rdata
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_cancel;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;

    logic        d_req;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  i_req, i_addr, i_cancel,
        input  d_req, d_we, d_addr, d_wdata,
        input  sram_rdata,
        output i_addr_ok, i_data_ok, i_rdata,
        output d_addr_ok, d_data_ok, d_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output i_req, i_addr, i_cancel,
        output d_req, d_we, d_addr, d_wdata,
        output sram_rdata,
        input  i_addr_ok, i_data_ok, i_rdata,
        input  d_addr_ok, d_data_ok, d_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port synchronous SRAM between the fetch stage (reads
// only) and the execute stage (loads/stores). One access is granted per
// cycle, combinationally in the request cycle. A LAT-deep tracker remembers
// who owns each in-flight access, so the completion pulse is routed back to
// the right requester LAT cycles after the grant.
// Parameters:
//   LAT    SRAM read latency, 1..3 cycles
//   STARVE consecutive fetch denials tolerated before fetch is forced to win, 1..15
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  mem_port_arbiter_if.slave (fetch, data and SRAM signal groups)
module mem_port_arbiter #(
    parameter int LAT    = 1,
    parameter int STARVE = 8
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE);

    logic           grant_i;
    logic           grant_d;
    logic           grant_any;
    logic [3:0]     starve_cnt;

    // Tracker stage k holds the access granted k+1 cycles ago.
    logic [LAT-1:0] trk_valid;
    logic [LAT-1:0] trk_fetch;

    // Data normally wins a collision. Once fetch has lost STARVE times in a
    // row it takes the port. A cancel cycle never grants fetch, so data
    // still goes through even when the starve limit has been reached.
    always_comb begin
        grant_i   = bus.i_req && !bus.i_cancel &&
                    (!bus.d_req || (starve_cnt == STARVE_LIM));
        grant_d   = bus.d_req && !grant_i;
        grant_any = grant_i || grant_d;
    end

    assign bus.i_addr_ok  = grant_i;
    assign bus.d_addr_ok  = grant_d;
    assign bus.sram_en    = grant_any;
    assign bus.sram_we    = grant_d ? bus.d_we : 4'h0;
    assign bus.sram_addr  = grant_d ? bus.d_addr : bus.i_addr;
    assign bus.sram_wdata = bus.d_wdata;

    // Read data goes to both requesters unqualified; the data_ok pulses say
    // whose it is.
    assign bus.i_rdata = bus.sram_rdata;
    assign bus.d_rdata = bus.sram_rdata;

    // A fetch leaving the tracker in a cancel cycle is suppressed here; the
    // squash of the remaining fetch entries happens on the edge below.
    assign bus.d_data_ok = trk_valid[LAT-1] && !trk_fetch[LAT-1];
    assign bus.i_data_ok = trk_valid[LAT-1] &&  trk_fetch[LAT-1] && !bus.i_cancel;

    // Counts consecutive cycles in which fetch was asking and lost. Any
    // cycle without a fetch request, or a flush, restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_i || !bus.i_req || bus.i_cancel) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // No stall: the tracker shifts every cycle. A cancel drops the valid bit
    // of every fetch-owned entry as it moves to the next stage; the entry
    // leaving the last stage is handled by the i_data_ok gating above.
    // Stage 0 never receives a fetch in a cancel cycle, so it needs no mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            trk_valid <= '0;
            trk_fetch <= '0;
        end else begin
            trk_valid[0] <= grant_any;
            trk_fetch[0] <= grant_i;
            for (int k = 1; k < LAT; k++) begin
                trk_valid[k] <= trk_valid[k-1] && !(bus.i_cancel && trk_fetch[k-1]);
                trk_fetch[k] <= trk_fetch[k-1];
            end
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous data/instruction SRAM between the fetch stage (read-only instruction requester) and the execute stage (load/store data requester). The block arbitrates one access per cycle and drives the SRAM port. It tracks every in-flight access through a latency pipeline so the read data and completion pulse return to the requester that issued it. It supports squashing in-flight fetches on a pipeline flush, and it prevents fetch starvation under sustained memory traffic.

## Interface
Parameters:
- LAT, 1, SRAM read latency in cycles (legal 1..3); read data valid LAT cycles after the enable cycle
- STARVE, 8, consecutive fetch denials tolerated before fetch is forced to win (legal 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  fetch read request
- i_addr  in  32  fetch address
- i_cancel  in  1  flush: squash every fetch granted in this cycle or earlier that has not completed
- i_addr_ok  out  1  fetch request accepted this cycle
- i_data_ok  out  1  fetch read data valid (one-cycle pulse)
- i_rdata  out  32  fetch read data
- d_req  in  1  data request
- d_we  in  4  byte write enables; 0 means read
- d_addr  in  32  data address
- d_wdata  in  32  write data
- d_addr_ok  out  1  data request accepted this cycle
- d_data_ok  out  1  data access complete; for reads, d_rdata is valid (one-cycle pulse)
- d_rdata  out  32  data read data
- sram_en  out  1  SRAM enable
- sram_we  out  4  SRAM byte write enables
- sram_addr  out  32  SRAM address
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data

## Operation
- Grant is combinational within the request cycle. At most one grant per cycle.
  - Only one requester active: that requester wins.
  - Both active: data wins, unless starve_cnt == STARVE, in which case fetch wins.
  - Fetch never wins in a cycle with i_cancel = 1; i_addr_ok = 0 in that cycle.
- Port drive:
  - sram_en = 1 when any grant is given.
  - Address comes from the winner.
  - sram_we = d_we when data wins, otherwise 0.
  - sram_wdata = d_wdata, unconditionally.
- starve_cnt (4-bit):
  - Increments, saturating at STARVE, in each cycle with i_req = 1, no fetch grant, and i_cancel = 0.
  - Clears on a fetch grant, or when i_req = 0 or i_cancel = 1.
- In-flight tracker: LAT-stage shift register, each stage {valid, owner}.
  - The grant cycle loads stage 1 with {1, winner}.
  - A cycle with no grant loads {0, x}.
  - Shifts every cycle; there is no stall.
- Completion, from stage LAT:
  - valid with owner = data: d_data_ok = 1.
  - valid with owner = fetch and not squashed: i_data_ok = 1.
- i_rdata = d_rdata = sram_rdata, combinational and unqualified; only meaningful when the matching data_ok is high.
- Squash: i_cancel = 1 clears the valid bit of every fetch-owned stage on the next edge. It also suppresses i_data_ok combinationally in the cancel cycle itself. Data-owned entries are unaffected.
- Writes complete identically to reads: d_data_ok fires at grant + LAT; d_rdata is don't-care.
- Requesters have no response backpressure; they must accept data_ok whenever it arrives.

## Timing
- Reset values: all tracker valid bits 0, starve_cnt 0. Consequently i_data_ok = d_data_ok = 0 in the first cycle after reset. Grant outputs follow the inputs combinationally.
- Request at cycle t, granted: addr_ok = 1 and the SRAM is driven in cycle t; data_ok is asserted in cycle t + LAT.
- Throughput: one access per cycle. Back-to-back grants to alternating owners complete in grant order.
- Reset mid-flight: all in-flight accesses are dropped, with no data_ok for any of them.
- Simultaneous i_cancel and a fetch completion in the same cycle: the completion is suppressed.
- i_cancel with i_req = 0: squashes in-flight fetches only.
- A data grant is legal in a cancel cycle.

## Test plan
1. LAT=1, only i_req, i_addr=0x1c000000 at cycle 5 -> i_addr_ok=1, sram_en=1, sram_we=0, sram_addr=0x1c000000 at cycle 5; i_data_ok=1 with i_rdata = model word at cycle 6.
2. LAT=1, i_req and d_req in the same cycle, d_we=0xF, d_addr=0x100, d_wdata=0xdeadbeef -> d_addr_ok=1, i_addr_ok=0, sram_we=0xF; d_data_ok at next cycle; subsequent read of 0x100 returns 0xdeadbeef.
3. STARVE=8, i_req and d_req held high for 12 cycles starting at cycle 0 -> data granted cycles 0-7; fetch granted cycle 8; data granted cycles 9-11; starve_cnt=0 after cycle 8.
4. LAT=2, fetch granted at t, data read granted at t+1, i_cancel=1 at t+1 -> no i_data_ok at t+2; d_data_ok at t+3; no fetch grant at t+1.
5. LAT=3, grants alternate fetch/data/fetch/data over 4 cycles -> data_ok pulses alternate i/d at t+3..t+6, each with the correct model data.
6. LAT=2, two reads in flight, rst asserted one cycle -> no data_ok in the following 3 cycles; starve_cnt=0; a new request after reset completes normally.
